// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL reset/lock supervisor.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_ctrl_state_t;

  // Width of the shared phase counter: it must reach (max of the three cycle counts) - 1.
  function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                            input int unsigned timeout_cycles,
                                            input int unsigned stable_cycles);
    int unsigned m;
    m = rst_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Width of the retry counter: it must hold 0..max_retries.
  function automatic int unsigned retry_width(input int unsigned max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// PLL-side and system-reset-side signals of the supervisor.
interface pll_reset_ctrl_if
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned MAX_RETRIES = 7
);
  localparam int unsigned RW = retry_width(MAX_RETRIES);

  logic          pll_locked;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          lock_lost;
  logic          fail;
  logic [RW-1:0] retry_count;

  // Supervisor side.
  modport master (
    input  pll_locked,
    output pll_rst, sys_rst_n, lock_lost, fail, retry_count
  );

  // PLL / consumer side.
  modport slave (
    output pll_locked,
    input  pll_rst, sys_rst_n, lock_lost, fail, retry_count
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back capture stages to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset and lock supervisor: pulses the PLL reset, qualifies lock, releases system reset.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 32,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input logic              clk,
  input logic              rst_n,
  pll_reset_ctrl_if.master pif
);
  localparam int unsigned CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int unsigned RW = retry_width(MAX_RETRIES);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  logic            lock_s;
  pll_ctrl_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_n_q, sys_rst_n_d;
  logic            lock_lost_q, lock_lost_d;
  logic            fail_q, fail_d;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pif.pll_locked),
    .q_o   (lock_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      lock_lost_q <= lock_lost_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state, counter, retry and output decode; outputs follow the next state so they are registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    unique case (state_q)
      RESET_PLL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cnt_d = cnt_q + CW'(1);
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = RESET_PLL;
          end else begin
            state_d = FAIL;
          end
        end
      end
      STABLE: begin
        cnt_d = cnt_q + CW'(1);
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          lock_lost_d = 1'b1;
          state_d     = RESET_PLL;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    // Every state entry restarts the shared counter.
    if (state_d != state_q) cnt_d = '0;

    pll_rst_d   = (state_d == RESET_PLL);
    sys_rst_n_d = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  assign pif.pll_rst     = pll_rst_q;
  assign pif.sys_rst_n   = sys_rst_n_q;
  assign pif.lock_lost   = lock_lost_q;
  assign pif.fail        = fail_q;
  assign pif.retry_count = retry_q;
endmodule
